// File: rtl/tlul_host_arb2_pkg.sv
// ============================================================================
// tlul_host_arb2_pkg : TL-UL types, widths and source-tag helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package tlul_host_arb2_pkg;

   localparam int TL_AW  = 32;
   localparam int TL_DW  = 32;
   localparam int TL_AIW = 8;
   localparam int TL_DBW = TL_DW / 8;
   localparam int TL_SZW = 2;
   localparam int TL_AUW = 16;
   localparam int TL_DUW = 16;
   localparam int TL_DIW = 1;

   localparam int HostIdW = 1;
   localparam int CntW    = 4;

   localparam logic [2:0] PutFullData    = 3'h0;
   localparam logic [2:0] PutPartialData = 3'h1;
   localparam logic [2:0] Get            = 3'h4;
   localparam logic [2:0] AccessAck      = 3'h0;
   localparam logic [2:0] AccessAckData  = 3'h1;

   typedef struct packed {
      logic                a_valid;
      logic [2:0]          a_opcode;
      logic [2:0]          a_param;
      logic [TL_SZW-1:0]   a_size;
      logic [TL_AIW-1:0]   a_source;
      logic [TL_AW-1:0]    a_address;
      logic [TL_DBW-1:0]   a_mask;
      logic [TL_DW-1:0]    a_data;
      logic [TL_AUW-1:0]   a_user;
      logic                d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic                d_valid;
      logic [2:0]          d_opcode;
      logic [2:0]          d_param;
      logic [TL_SZW-1:0]   d_size;
      logic [TL_AIW-1:0]   d_source;
      logic [TL_DIW-1:0]   d_sink;
      logic [TL_DW-1:0]    d_data;
      logic [TL_DUW-1:0]   d_user;
      logic                d_error;
      logic                a_ready;
   } tl_d2h_t;

   typedef enum logic [1:0] {
      ArbIdle  = 2'd0,
      ArbLock0 = 2'd1,
      ArbLock1 = 2'd2
   } arb_state_e;

   // Host index lives in the low source bits so responses route on d_source[0].
   function automatic logic [TL_AIW-1:0] tag_source(input logic [TL_AIW-1:0] src,
                                                    input logic [HostIdW-1:0] host);
      return {src[TL_AIW-HostIdW-1:0], host};
   endfunction

   function automatic logic [TL_AIW-1:0] untag_source(input logic [TL_AIW-1:0] src);
      return {{HostIdW{1'b0}}, src[TL_AIW-1:HostIdW]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/tlul_host_arb2_rr.sv
// ============================================================================
// tlul_host_arb2_rr : two-input round-robin arbiter holding grant until accept
// Revision: 1.0
// ============================================================================
`default_nettype none

module tlul_host_arb2_rr
   import tlul_host_arb2_pkg::*;
#(
   parameter logic H0Priority = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   input  logic [1:0] valid_i,
   input  logic       ready_i,
   output logic [1:0] gnt_o
);

   arb_state_e state_q, state_d;
   logic       ptr_q, ptr_d;   // host favoured when both are eligible
   logic [1:0] gnt;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt     = 2'b00;
      unique case (state_q)
         ArbLock0: begin
            if (valid_i[0]) gnt = 2'b01;
            else            state_d = ArbIdle;
         end
         ArbLock1: begin
            if (valid_i[1]) gnt = 2'b10;
            else            state_d = ArbIdle;
         end
         default: begin
            if (req_i == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
            else                gnt = req_i;
         end
      endcase
      if (gnt != 2'b00) begin
         if (ready_i) begin
            state_d = ArbIdle;
            ptr_d   = gnt[0];
         end else begin
            state_d = gnt[1] ? ArbLock1 : ArbLock0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ArbIdle;
         ptr_q   <= ~H0Priority;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   assign gnt_o = gnt;

   a_lock0_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state_q == ArbLock0) |-> valid_i[0]);
   a_lock1_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state_q == ArbLock1) |-> valid_i[1]);

endmodule

`default_nettype wire

// File: rtl/tlul_host_arb2.sv
// ============================================================================
// tlul_host_arb2 : merges two TL-UL hosts onto one device port with source tags
// Revision: 1.0
// ============================================================================
`default_nettype none

module tlul_host_arb2
   import tlul_host_arb2_pkg::*;
#(
   parameter int unsigned MaxOutstanding = 2,
   parameter logic        H0Priority     = 1'b1
) (
   input  logic    clk_i,
   input  logic    rst_ni,
   input  tl_h2d_t tl_h0_i,
   output tl_d2h_t tl_h0_o,
   input  tl_h2d_t tl_h1_i,
   output tl_d2h_t tl_h1_o,
   output tl_h2d_t tl_d_o,
   input  tl_d2h_t tl_d_i
);

   localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

   logic [1:0]            host_valid, host_src_msb, elig, gnt_raw, gnt, a_acc, d_done;
   logic [1:0][CntW-1:0]  cnt_q, cnt_d;
   logic [HostIdW-1:0]    a_sel, d_tgt;
   logic                  d_ready_dev, d_fire;

   function automatic logic [CntW-1:0] next_cnt(input logic [CntW-1:0] c,
                                                input logic inc, input logic dec);
      if (inc && !dec)              return c + 1'b1;
      if (dec && !inc && c != '0)   return c - 1'b1;
      return c;
   endfunction

   function automatic tl_d2h_t route_d(input tl_d2h_t d, input logic hit, input logic a_rdy);
      tl_d2h_t r;
      r          = d;
      r.d_valid  = d.d_valid & hit;
      r.d_source = untag_source(d.d_source);
      r.a_ready  = a_rdy;
      return r;
   endfunction

   assign host_valid   = {tl_h1_i.a_valid, tl_h0_i.a_valid};
   assign host_src_msb = {tl_h1_i.a_source[TL_AIW-1], tl_h0_i.a_source[TL_AIW-1]};
   assign elig[0]      = host_valid[0] && (cnt_q[0] < MaxCnt);
   assign elig[1]      = host_valid[1] && (cnt_q[1] < MaxCnt);

   tlul_host_arb2_rr #(
      .H0Priority (H0Priority)
   ) u_arb (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .req_i   (elig),
      .valid_i (host_valid),
      .ready_i (tl_d_i.a_ready),
      .gnt_o   (gnt_raw)
   );

   // Reset forces every handshake output low immediately, not at the next edge.
   assign gnt   = gnt_raw & {2{rst_ni}};
   assign a_sel = gnt[1];
   assign a_acc = gnt & {2{tl_d_i.a_ready}};

   assign d_tgt       = tl_d_i.d_source[0];
   assign d_ready_dev = rst_ni & (d_tgt[0] ? tl_h1_i.d_ready : tl_h0_i.d_ready);
   assign d_fire      = tl_d_i.d_valid & d_ready_dev;
   assign d_done      = {d_fire & d_tgt[0], d_fire & ~d_tgt[0]};

   always_comb begin
      tl_d_o          = a_sel[0] ? tl_h1_i : tl_h0_i;
      tl_d_o.a_valid  = |gnt;
      tl_d_o.a_source = tag_source(a_sel[0] ? tl_h1_i.a_source : tl_h0_i.a_source, a_sel);
      tl_d_o.d_ready  = d_ready_dev;
   end

   assign tl_h0_o = route_d(tl_d_i, rst_ni & ~d_tgt[0], tl_d_i.a_ready & gnt[0]);
   assign tl_h1_o = route_d(tl_d_i, rst_ni &  d_tgt[0], tl_d_i.a_ready & gnt[1]);

   assign cnt_d[0] = next_cnt(cnt_q[0], a_acc[0], d_done[0]);
   assign cnt_d[1] = next_cnt(cnt_q[1], a_acc[1], d_done[1]);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   for (genvar h = 0; h < 2; h++) begin : g_chk
      a_src_msb: assert property (@(posedge clk_i) disable iff (!rst_ni)
         host_valid[h] |-> !host_src_msb[h]);
      a_inc_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
         a_acc[h] |-> (cnt_q[h] < MaxCnt));
      a_dec_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
         d_done[h] |-> (cnt_q[h] != '0));
   end

endmodule

`default_nettype wire

// File: tb/tb_tlul_host_arb2.sv
// ============================================================================
// tb_tlul_host_arb2 : scoreboard bench for the two-host TL-UL arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tlul_host_arb2;
   import tlul_host_arb2_pkg::*;

   logic    clk_i = 1'b0;
   logic    rst_ni = 1'b0;
   tl_h2d_t tl_h0_i, tl_h1_i, tl_d_o;
   tl_d2h_t tl_h0_o, tl_h1_o, tl_d_i;

   int checks = 0;
   int errors = 0;

   typedef struct { logic [31:0] addr; logic [7:0] src; } exp_a_t;
   typedef struct { logic host; logic [7:0] src; logic [31:0] data; } exp_d_t;
   exp_a_t exp_a_q[$];
   exp_d_t exp_d_q[$];

   always #5 clk_i = ~clk_i;

   tlul_host_arb2 #(.MaxOutstanding(2), .H0Priority(1'b1)) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .tl_h0_i (tl_h0_i),
      .tl_h0_o (tl_h0_o),
      .tl_h1_i (tl_h1_i),
      .tl_h1_o (tl_h1_o),
      .tl_d_o  (tl_d_o),
      .tl_d_i  (tl_d_i)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic host_req(input int h, input logic v, input logic [31:0] addr, input logic [7:0] src);
      tl_h2d_t r;
      r = (h == 0) ? tl_h0_i : tl_h1_i;
      r.a_valid = v; r.a_opcode = Get; r.a_param = 3'h0; r.a_size = 2'd2;
      r.a_source = src; r.a_address = addr; r.a_mask = 4'hf; r.a_data = '0; r.a_user = '0;
      if (h == 0) tl_h0_i = r; else tl_h1_i = r;
   endtask

   task automatic dev_resp(input logic v, input logic [7:0] src, input logic [31:0] data);
      tl_d_i.d_valid = v; tl_d_i.d_opcode = AccessAckData; tl_d_i.d_param = 3'h0;
      tl_d_i.d_size = 2'd2; tl_d_i.d_source = src; tl_d_i.d_sink = '0;
      tl_d_i.d_data = data; tl_d_i.d_user = '0; tl_d_i.d_error = 1'b0;
   endtask

   task automatic push_a(input logic [31:0] addr, input logic [7:0] src);
      exp_a_t e; e.addr = addr; e.src = src; exp_a_q.push_back(e);
   endtask

   // Device response with a tagged source: the expected host view is untagged.
   task automatic push_d_for(input logic [7:0] dev_src, input logic [31:0] data);
      exp_d_t e; e.host = dev_src[0]; e.src = {1'b0, dev_src[7:1]}; e.data = data;
      exp_d_q.push_back(e);
   endtask

   task automatic d_check(input logic h, input tl_d2h_t d);
      exp_d_t e;
      if (exp_d_q.size() == 0) begin
         check_eq("d_unexpected", d.d_valid, 1'b0);
      end else begin
         e = exp_d_q.pop_front();
         check_eq("d_host", h, e.host);
         check_eq("d_source", d.d_source, e.src);
         check_eq("d_data", d.d_data, e.data);
      end
   endtask

   always @(negedge clk_i) begin
      if (rst_ni && tl_d_o.a_valid && tl_d_i.a_ready) begin
         if (exp_a_q.size() == 0) begin
            check_eq("a_unexpected", tl_d_o.a_valid, 1'b0);
         end else begin
            exp_a_t e;
            e = exp_a_q.pop_front();
            check_eq("a_address", tl_d_o.a_address, e.addr);
            check_eq("a_source", tl_d_o.a_source, e.src);
         end
      end
      if (tl_h0_o.d_valid && tl_h0_i.d_ready) d_check(1'b0, tl_h0_o);
      if (tl_h1_o.d_valid && tl_h1_i.d_ready) d_check(1'b1, tl_h1_o);
   end

   task automatic queues_empty(input string tag);
      check_eq({tag, "_a_left"}, exp_a_q.size(), 0);
      check_eq({tag, "_d_left"}, exp_d_q.size(), 0);
      exp_a_q.delete();
      exp_d_q.delete();
   endtask

   task automatic do_reset();
      host_req(0, 1'b0, 32'h0, 8'h0);
      host_req(1, 1'b0, 32'h0, 8'h0);
      dev_resp(1'b0, 8'h0, 32'h0);
      tl_d_i.a_ready = 1'b1;
      rst_ni = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      cyc();
   endtask

   initial begin
      tl_h0_i = '0; tl_h1_i = '0; tl_d_i = '0;
      tl_h0_i.d_ready = 1'b1; tl_h1_i.d_ready = 1'b1;
      tl_d_i.a_ready = 1'b1;

      // Reset state: outputs held low even with live requests and a response.
      host_req(0, 1'b1, 32'h1000, 8'h0);
      host_req(1, 1'b1, 32'h1100, 8'h0);
      dev_resp(1'b1, 8'h00, 32'h1234);
      #3;
      check_eq("rst_dev_a_valid", tl_d_o.a_valid, 1'b0);
      check_eq("rst_h0_a_ready", tl_h0_o.a_ready, 1'b0);
      check_eq("rst_h1_a_ready", tl_h1_o.a_ready, 1'b0);
      check_eq("rst_h0_d_valid", tl_h0_o.d_valid, 1'b0);
      check_eq("rst_dev_d_ready", tl_d_o.d_ready, 1'b0);
      do_reset();

      // Single host Get and its response.
      host_req(0, 1'b1, 32'h1000, 8'h0);
      push_a(32'h1000, 8'h00);
      #2;
      check_eq("s1_h0_a_ready", tl_h0_o.a_ready, 1'b1);
      check_eq("s1_h1_a_ready", tl_h1_o.a_ready, 1'b0);
      cyc();
      host_req(0, 1'b0, 32'h0, 8'h0);
      dev_resp(1'b1, 8'h00, 32'hCAFE0001);
      push_d_for(8'h00, 32'hCAFE0001);
      #2;
      check_eq("s1_h1_d_valid", tl_h1_o.d_valid, 1'b0);
      check_eq("s1_dev_d_ready", tl_d_o.d_ready, 1'b1);
      cyc();
      dev_resp(1'b0, 8'h0, 32'h0);
      queues_empty("s1");

      // Contention from reset: h0 first, then alternate until both hit the limit.
      do_reset();
      host_req(0, 1'b1, 32'h2000, 8'h1);
      host_req(1, 1'b1, 32'h3000, 8'h2);
      for (int i = 0; i < 2; i++) begin
         push_a(32'h2000, 8'h02);
         push_a(32'h3000, 8'h05);
      end
      for (int i = 0; i < 4; i++) begin
         #2;
         check_eq("s2_order", tl_d_o.a_source, (i % 2 == 1) ? 8'h05 : 8'h02);
         cyc();
      end
      #2;
      check_eq("s2_both_at_limit", tl_d_o.a_valid, 1'b0);
      host_req(0, 1'b0, 32'h0, 8'h0);
      host_req(1, 1'b0, 32'h0, 8'h0);
      for (int i = 0; i < 4; i++) begin
         logic [7:0] s;
         s = (i % 2 == 1) ? 8'h05 : 8'h02;
         dev_resp(1'b1, s, 32'hD000_0000 + 32'(i));
         push_d_for(s, 32'hD000_0000 + 32'(i));
         cyc();
      end
      dev_resp(1'b0, 8'h0, 32'h0);
      queues_empty("s2");

      // Backpressure lock on h1; h0 arrives while locked and must wait.
      do_reset();
      tl_d_i.a_ready = 1'b0;
      host_req(1, 1'b1, 32'h5000, 8'h6);
      #2;
      check_eq("s3_first_grant_src", tl_d_o.a_source, 8'h0D);
      cyc();
      host_req(0, 1'b1, 32'h6000, 8'h7);
      for (int i = 0; i < 5; i++) begin
         #2;
         check_eq("s3_lock_addr", tl_d_o.a_address, 32'h5000);
         check_eq("s3_lock_src", tl_d_o.a_source, 8'h0D);
         check_eq("s3_lock_h0_a_ready", tl_h0_o.a_ready, 1'b0);
         cyc();
      end
      tl_d_i.a_ready = 1'b1;
      push_a(32'h5000, 8'h0D);
      push_a(32'h6000, 8'h0E);
      #2;
      check_eq("s3_release_h1", tl_h1_o.a_ready, 1'b1);
      check_eq("s3_release_h0", tl_h0_o.a_ready, 1'b0);
      cyc();
      host_req(1, 1'b0, 32'h0, 8'h0);
      #2;
      check_eq("s3_then_h0", tl_h0_o.a_ready, 1'b1);
      cyc();
      host_req(0, 1'b0, 32'h0, 8'h0);
      queues_empty("s3");

      // Outstanding limit, same-cycle accept+response, d_ready backpressure.
      do_reset();
      host_req(0, 1'b1, 32'h4000, 8'h3);
      push_a(32'h4000, 8'h06);
      push_a(32'h4000, 8'h06);
      #2; check_eq("s4_h0_1st", tl_h0_o.a_ready, 1'b1);
      cyc();
      #2; check_eq("s4_h0_2nd", tl_h0_o.a_ready, 1'b1);
      cyc();
      host_req(1, 1'b1, 32'h7000, 8'h4);
      push_a(32'h7000, 8'h09);
      #2;
      check_eq("s4_h0_stall", tl_h0_o.a_ready, 1'b0);
      check_eq("s4_h1_passes", tl_h1_o.a_ready, 1'b1);
      cyc();
      host_req(1, 1'b0, 32'h0, 8'h0);
      dev_resp(1'b1, 8'h06, 32'hAAAA0001);
      push_d_for(8'h06, 32'hAAAA0001);
      #2; check_eq("s4_still_full", tl_d_o.a_valid, 1'b0);
      cyc();
      dev_resp(1'b0, 8'h0, 32'h0);
      push_a(32'h4000, 8'h06);
      #2; check_eq("s4_h0_after_resp", tl_h0_o.a_ready, 1'b1);
      cyc();
      host_req(0, 1'b0, 32'h0, 8'h0);
      host_req(1, 1'b1, 32'h7100, 8'h4);
      push_a(32'h7100, 8'h09);
      dev_resp(1'b1, 8'h09, 32'hBBBB0001);
      push_d_for(8'h09, 32'hBBBB0001);
      #2;
      check_eq("s4_same_cyc_a", tl_h1_o.a_ready, 1'b1);
      check_eq("s4_same_cyc_d", tl_h1_o.d_valid, 1'b1);
      cyc();
      dev_resp(1'b0, 8'h0, 32'h0);
      host_req(1, 1'b1, 32'h7200, 8'h4);
      push_a(32'h7200, 8'h09);
      #2; check_eq("s4_cnt1_held", tl_h1_o.a_ready, 1'b1);
      cyc();
      host_req(1, 1'b1, 32'h7300, 8'h4);
      tl_h1_i.d_ready = 1'b0;
      dev_resp(1'b1, 8'h09, 32'hBBBB0002);
      #2;
      check_eq("s4_h1_limit", tl_h1_o.a_ready, 1'b0);
      check_eq("s4_dev_d_ready_bp", tl_d_o.d_ready, 1'b0);
      check_eq("s4_h1_d_valid_bp", tl_h1_o.d_valid, 1'b1);
      cyc();
      host_req(1, 1'b0, 32'h0, 8'h0);
      tl_h1_i.d_ready = 1'b1;
      push_d_for(8'h09, 32'hBBBB0002);
      #2; check_eq("s4_dev_d_ready", tl_d_o.d_ready, 1'b1);
      cyc();
      dev_resp(1'b0, 8'h0, 32'h0);
      queues_empty("s4");

      // Asynchronous reset while h0 is locked.
      do_reset();
      host_req(0, 1'b1, 32'h8000, 8'h5);
      push_a(32'h8000, 8'h0A);
      cyc();
      host_req(0, 1'b1, 32'h8100, 8'h5);
      tl_d_i.a_ready = 1'b0;
      cyc();
      #2; check_eq("s5_locked_valid", tl_d_o.a_valid, 1'b1);
      rst_ni = 1'b0;
      #1;
      check_eq("s5_rst_a_valid", tl_d_o.a_valid, 1'b0);
      check_eq("s5_rst_h0_a_ready", tl_h0_o.a_ready, 1'b0);
      host_req(0, 1'b0, 32'h0, 8'h0);
      tl_d_i.a_ready = 1'b1;
      @(negedge clk_i);
      rst_ni = 1'b1;
      cyc();
      host_req(1, 1'b1, 32'h9000, 8'h1);
      push_a(32'h9000, 8'h03);
      #2; check_eq("s5_h1_at_once", tl_h1_o.a_ready, 1'b1);
      cyc();
      host_req(1, 1'b0, 32'h0, 8'h0);
      host_req(0, 1'b1, 32'hA000, 8'h0);
      push_a(32'hA000, 8'h00);
      push_a(32'hA000, 8'h00);
      #2; check_eq("s5_cnt0_clr_1", tl_h0_o.a_ready, 1'b1);
      cyc();
      #2; check_eq("s5_cnt0_clr_2", tl_h0_o.a_ready, 1'b1);
      cyc();
      #2; check_eq("s5_cnt0_limit", tl_h0_o.a_ready, 1'b0);
      host_req(0, 1'b0, 32'h0, 8'h0);
      cyc();
      queues_empty("s5");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1);
   end

endmodule

`default_nettype wire
